// File: rtl/masked_sbox_sched.sv
// masked_sbox_sched
// -----------------
// Round-level scheduler for the third-order masked AES SubBytes stage.
// It walks the shared table-recomputation S-box unit over every state byte,
// one byte at a time. For each byte the sequence is:
//   1. share divide
//   2. one adjust/refresh pair for every non-final share
//   3. table lookup
//   4. byte write-back
// It also owns the request/valid handshake to the fresh-randomness source.
//
// Parameters:
//   NBYTES   state bytes per pass (power of two, 2..16)
//   NSHARES  masking shares, order+1 (2..8)
//   RW       width of rnd_data_i
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   start_i        begin a pass (sampled only while idle)
//   busy_o         pass in progress, including the done cycle
//   done_o         one-cycle pulse at the end of a pass
//   divide_en_o    split the current byte into shares
//   adjust_en_o    adjust the table with share adjust_sel_o
//   adjust_sel_o   share index 0..NSHARES-2
//   rnd_req_o      request a fresh mask
//   rnd_valid_i    randomness available this cycle
//   rnd_data_i     random word (consumed only when shuffling is enabled)
//   refresh_en_o   refresh the table with the fresh mask
//   address_en_o   read the masked output shares
//   byte_wr_o      write the result shares back
//   byte_idx_o     state byte currently processed
//
// Build option:
//   SCHED_SHUFFLE_EN  When defined, each pass first fetches a random offset.
//                     The bytes are then visited in rotated order.
`timescale 1ns/1ps

module masked_sbox_sched #(
    parameter int NBYTES  = 16,
    parameter int NSHARES = 4,
    parameter int RW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          divide_en_o,
    output logic          adjust_en_o,
    output logic [2:0]    adjust_sel_o,
    output logic          rnd_req_o,
    input  logic          rnd_valid_i,
    input  logic [RW-1:0] rnd_data_i,
    output logic          refresh_en_o,
    output logic          address_en_o,
    output logic          byte_wr_o,
    output logic [3:0]    byte_idx_o
);

    // state   | meaning
    // --------+--------------------------------------------------------
    // IDLE    | waiting for start
    // SEED    | (shuffle builds) waiting for the random byte offset
    // DIVIDE  | split current byte into shares
    // ADJUST  | adjust table with share k
    // REFRESH | request a fresh mask; stall until rnd_valid_i
    // LOOKUP  | read masked output shares
    // WRITE   | write result shares back, advance the byte counter
    // DONE    | end-of-pass pulse, counters cleared

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DIVIDE  = 3'd1;
    localparam logic [2:0] S_ADJUST  = 3'd2;
    localparam logic [2:0] S_REFRESH = 3'd3;
    localparam logic [2:0] S_LOOKUP  = 3'd4;
    localparam logic [2:0] S_WRITE   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
`ifdef SCHED_SHUFFLE_EN
    localparam logic [2:0] S_SEED    = 3'd7;
`endif

    // NBYTES is a power of two, so the last index also serves as the wrap mask.
    localparam logic [3:0] CNT_LAST = 4'(NBYTES - 1);
    localparam logic [2:0] K_LAST   = 3'(NSHARES - 2);

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] k_q, k_d;
    logic [3:0] idx_d;
    logic       in_byte_d;

    logic       busy_q, done_q, divide_en_q, adjust_en_q, rnd_req_q;
    logic       address_en_q, byte_wr_q;
    logic [2:0] adjust_sel_q;
    logic [3:0] byte_idx_q;

    // In the default build rnd_data_i is unused.
    // When shuffling, only its low bits are used.
    logic unused_rnd;
    assign unused_rnd = ^rnd_data_i;

`ifdef SCHED_SHUFFLE_EN
    logic [3:0] off_q, off_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
`ifdef SCHED_SHUFFLE_EN
        off_d   = off_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cnt_d   = 4'd0;
                    k_d     = 3'd0;
`ifdef SCHED_SHUFFLE_EN
                    state_d = S_SEED;
`else
                    state_d = S_DIVIDE;
`endif
                end
            end
`ifdef SCHED_SHUFFLE_EN
            S_SEED: begin
                if (rnd_valid_i) begin
                    off_d   = 4'(rnd_data_i) & CNT_LAST;
                    state_d = S_DIVIDE;
                end
            end
`endif
            S_DIVIDE: begin
                k_d     = 3'd0;
                state_d = S_ADJUST;
            end
            S_ADJUST: begin
                state_d = S_REFRESH;
            end
            S_REFRESH: begin
                if (rnd_valid_i) begin
                    if (k_q < K_LAST) begin
                        k_d     = k_q + 3'd1;
                        state_d = S_ADJUST;
                    end else begin
                        state_d = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                    state_d = S_DIVIDE;
                end
            end
            S_DONE: begin
                cnt_d   = 4'd0;
                k_d     = 3'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The byte index is only published while a byte is being processed.
    // It therefore stays constant from DIVIDE through WRITE.
    assign in_byte_d = (state_d == S_DIVIDE) || (state_d == S_ADJUST) ||
                       (state_d == S_REFRESH) || (state_d == S_LOOKUP) ||
                       (state_d == S_WRITE);

`ifdef SCHED_SHUFFLE_EN
    assign idx_d = (cnt_d + off_d) & CNT_LAST;
`else
    assign idx_d = cnt_d;
`endif

    // Outputs are decoded from the next state, so they are registered.
    // Each output lines up with the cycle its state occupies.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            k_q          <= 3'd0;
`ifdef SCHED_SHUFFLE_EN
            off_q        <= 4'd0;
`endif
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            divide_en_q  <= 1'b0;
            adjust_en_q  <= 1'b0;
            adjust_sel_q <= 3'd0;
            rnd_req_q    <= 1'b0;
            address_en_q <= 1'b0;
            byte_wr_q    <= 1'b0;
            byte_idx_q   <= 4'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            k_q          <= k_d;
`ifdef SCHED_SHUFFLE_EN
            off_q        <= off_d;
`endif
            busy_q       <= (state_d != S_IDLE);
            done_q       <= (state_d == S_DONE);
            divide_en_q  <= (state_d == S_DIVIDE);
            adjust_en_q  <= (state_d == S_ADJUST);
            adjust_sel_q <= (state_d == S_IDLE) ? 3'd0 : k_d;
`ifdef SCHED_SHUFFLE_EN
            rnd_req_q    <= (state_d == S_REFRESH) || (state_d == S_SEED);
`else
            rnd_req_q    <= (state_d == S_REFRESH);
`endif
            address_en_q <= (state_d == S_LOOKUP);
            byte_wr_q    <= (state_d == S_WRITE);
            byte_idx_q   <= in_byte_d ? idx_d : 4'd0;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign divide_en_o  = divide_en_q;
    assign adjust_en_o  = adjust_en_q;
    assign adjust_sel_o = adjust_sel_q;
    assign rnd_req_o    = rnd_req_q;
    assign address_en_o = address_en_q;
    assign byte_wr_o    = byte_wr_q;
    assign byte_idx_o   = byte_idx_q;

    // refresh_en_o must fire in the same cycle the fresh mask is valid.
    // It is therefore the one output that combines a registered state bit
    // with rnd_valid_i.
    assign refresh_en_o = (state_q == S_REFRESH) && rnd_valid_i;

endmodule

// File: doc/masked_sbox_sched.md
Name: masked_sbox_sched

Overview:
- Round-level scheduler for the third-order masked AES SubBytes stage.
- Walks the shared table-recomputation S-box unit over every state byte, one byte at a time. For each byte it pulses share-divide, then alternating adjust/refresh for each non-final share, then table lookup, then byte write-back.
- Sits between the round controller (start/done) and the S-box datapath. Owns the handshake to the fresh-randomness source.

Parameters:
- NBYTES, 16: state bytes per pass. Power of two, 2..16.
- NSHARES, 4: masking shares (order+1). Range 2..8. Adjust/refresh pairs per byte = NSHARES-1.
- RW, 8: width of rnd_data.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a pass. Sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse at pass end.
- divide_en  out  1  split current byte into shares.
- adjust_en  out  1  adjust table with share adjust_sel.
- adjust_sel  out  3  share index 0..NSHARES-2. Held stable between adjust steps.
- rnd_req  out  1  request fresh mask for table refresh.
- rnd_valid  in  1  randomness available this cycle.
- rnd_data  in  RW  random word. Used only with the optional feature.
- refresh_en  out  1  refresh table with fresh mask.
- address_en  out  1  read masked output shares y0..y(NSHARES-1).
- byte_wr  out  1  write result shares back.
- byte_idx  out  4  state byte currently processed.

Behaviour:
- Reset: state IDLE, byte counter 0, share counter 0. All outputs 0: busy, done, divide_en, adjust_en, adjust_sel, rnd_req, refresh_en, address_en, byte_wr, byte_idx.
- All outputs are registered (Moore). Each strobe is high only during its state cycle.
- States:
  - IDLE: start=1 -> DIVIDE (SEED if feature on). Else stay.
  - DIVIDE (1 cycle, divide_en=1) -> ADJUST with share counter k=0.
  - ADJUST (1 cycle, adjust_en=1, adjust_sel=k) -> REFRESH.
  - REFRESH (rnd_req=1): waits while rnd_valid=0. refresh_en=1 only in the cycle rnd_valid=1 is seen. Then k<NSHARES-2 -> k+1, ADJUST; else -> LOOKUP.
  - LOOKUP (1 cycle, address_en=1) -> WRITE.
  - WRITE (1 cycle, byte_wr=1) -> byte counter = NBYTES-1 ? DONE : counter+1, DIVIDE.
  - DONE (1 cycle, done=1, busy=1) -> IDLE. Counters cleared.
- No stalls: 2*(NSHARES-1)+3 cycles per byte (9 at default). done is asserted NBYTES*9+1 = 145 cycles after the start cycle at defaults.
- byte_idx is valid and constant from DIVIDE through WRITE of each byte. Counter wraps to 0 only via DONE.
- start while busy: ignored, no queuing.
- rnd_valid outside REFRESH: ignored.
- rnd_req stays high across consecutive stall cycles. Dropped the cycle after acceptance.
- rst mid-pass overrides everything: next cycle IDLE with reset values, no done pulse. rst together with start: rst wins.
- NSHARES=2: exactly one ADJUST/REFRESH pair per byte.

Optional Feature:
- Macro: SCHED_SHUFFLE_EN.
- Defined:
  - IDLE+start -> SEED state. rnd_req=1, busy=1; waits for rnd_valid.
  - Latches offset = rnd_data[log2(NBYTES)-1:0], then -> DIVIDE.
  - byte_idx = (byte counter + offset) mod NBYTES, giving a random byte order per pass.
  - Adds 1 cycle plus rnd stalls to pass latency.
- Undefined: no SEED state, byte_idx = byte counter, rnd_data unused. Latency as above.

Test Plan:
- Reset then idle, rnd_valid tied 1: all outputs 0. start pulse -> busy next cycle; divide_en on cycle 1; done exactly at cycle 145; 16 byte_wr pulses with byte_idx 0..15 in order.
- rnd_valid held 0 for 3 cycles in the first REFRESH -> rnd_req high 4 cycles; refresh_en single pulse on the valid cycle; done shifted by +3.
- Count per byte at NSHARES=4 -> 3 adjust_en pulses with adjust_sel 0,1,2 in order; each followed by one refresh_en pulse; then 1 address_en, then 1 byte_wr.
- start re-pulsed at cycles 10 and 50 during a pass -> no effect; done still once at 145. rst at cycle 60 -> all outputs 0 at cycle 61, no done pulse. A following start runs a full pass from byte 0.
- SCHED_SHUFFLE_EN, rnd_data=8'h0D at seed -> byte_idx order 13,14,15,0,...,12; done at cycle 146 with no stalls.
- NSHARES=2, NBYTES=4 -> 5 cycles per byte, done at cycle 21, adjust_sel always 0.
